// File: rtl/vai_audit_tx.sv
// Per-sub-AFU Tx auditor: relocates request addresses, stamps the VMID into mdata,
// tracks outstanding requests and drains the sub-AFU to quiescence on sub_reset.
package vai_audit_pkg;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                            eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6} t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    logic [1:0]   cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    logic [1:0]   cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module vai_audit_tx
  import vai_audit_pkg::*;
#(
  parameter int VMID_WIDTH = 3,
  parameter int VMID       = 0,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sub_reset,
  input  logic [63:0]          offset,
  input  t_if_ccip_c0_Tx       af_c0_tx,
  input  t_if_ccip_c1_Tx       af_c1_tx,
  input  t_if_ccip_Rx          af_rx,
  output t_if_ccip_c0_Tx       out_c0_tx,
  output t_if_ccip_c1_Tx       out_c1_tx,
  output logic                 quiesced,
  output logic [31:0]          drop_cnt,
  output logic                 err_underflow,
  output logic [1:0]           dbg_state,
  output logic [CNT_WIDTH-1:0] dbg_rd_cnt,
  output logic [CNT_WIDTH-1:0] dbg_wr_cnt
);
  // Requests are valid-only (no ready): a request is consumed in the cycle its valid
  // is high and either issued one cycle later or dropped and counted.
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HELD = 2'd2} t_state;

  localparam logic [VMID_WIDTH-1:0] VMID_BITS = VMID_WIDTH'(VMID);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  t_state                 state_q, state_d;
  t_if_ccip_c0_Tx         out_c0_q, out_c0_d;
  t_if_ccip_c1_Tx         out_c1_q, out_c1_d;
  logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [31:0]            drop_cnt_q, drop_cnt_d;
  logic                   err_q, err_d;

  logic [42:0]            sum0, sum1;
  logic                   accept, c1_fence, issue0, issue1, drop0, drop1;
  logic [2:0]             rd_inc, rd_dec, wr_inc, wr_dec;
  logic                   rd_uf, wr_uf;

  // Returns {underflow, next_count}; a net decrement past zero clamps to zero.
  function automatic logic [CNT_WIDTH:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                  input logic [2:0] inc,
                                                  input logic [2:0] dec);
    logic [CNT_WIDTH+1:0] up;
    up = {2'b00, cnt} + (CNT_WIDTH+2)'(inc);
    if (up < (CNT_WIDTH+2)'(dec)) return {1'b1, {CNT_WIDTH{1'b0}}};
    up = up - (CNT_WIDTH+2)'(dec);
    if (up > {2'b00, CNT_MAX}) return {1'b0, CNT_MAX};
    return {1'b0, up[CNT_WIDTH-1:0]};
  endfunction

  always_comb begin
    accept   = (state_q == ST_RUN);
    c1_fence = (af_c1_tx.hdr.req_type == eREQ_WRFENCE);
    sum0     = {1'b0, af_c0_tx.hdr.address} + {1'b0, offset[41:0]};
    sum1     = {1'b0, af_c1_tx.hdr.address} + {1'b0, offset[41:0]};
    issue0   = af_c0_tx.valid && accept && !sum0[42];
    issue1   = af_c1_tx.valid && accept && (c1_fence || !sum1[42]);
    drop0    = af_c0_tx.valid && !issue0;
    drop1    = af_c1_tx.valid && !issue1;

    out_c0_d                          = af_c0_tx;
    out_c0_d.valid                    = issue0;
    out_c0_d.hdr.address              = sum0[41:0];
    out_c0_d.hdr.mdata[15 -: VMID_WIDTH] = VMID_BITS;

    out_c1_d                          = af_c1_tx;
    out_c1_d.valid                    = issue1;
    out_c1_d.hdr.address              = c1_fence ? af_c1_tx.hdr.address : sum1[41:0];
    out_c1_d.hdr.mdata[15 -: VMID_WIDTH] = VMID_BITS;

    rd_inc = {2'b00, issue0};
    rd_dec = {2'b00, af_rx.c0.rspValid && (af_rx.c0.hdr.resp_type == eRSP_RDLINE)};
    wr_inc = 3'd0;
    if (issue1) begin
      if (c1_fence)                wr_inc = 3'd1;
      else if (af_c1_tx.hdr.sop)   wr_inc = 3'(af_c1_tx.hdr.cl_len) + 3'd1;
    end
    wr_dec = 3'd0;
    if (af_rx.c1.rspValid)
      wr_dec = af_rx.c1.hdr.format ? 3'(af_rx.c1.hdr.cl_num) + 3'd1 : 3'd1;

    {rd_uf, rd_cnt_d} = cnt_next(rd_cnt_q, rd_inc, rd_dec);
    {wr_uf, wr_cnt_d} = cnt_next(wr_cnt_q, wr_inc, wr_dec);
    err_d      = err_q | rd_uf | wr_uf;
    drop_cnt_d = drop_cnt_q + 32'(drop0) + 32'(drop1);
  end

  // Drain exit looks at post-update counts so the state moves on the edge that
  // retires the last response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (sub_reset) state_d = ST_DRAIN;
      ST_DRAIN: if (rd_cnt_d == '0 && wr_cnt_d == '0) state_d = sub_reset ? ST_HELD : ST_RUN;
      ST_HELD:  if (!sub_reset) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      out_c0_q   <= '0;
      out_c1_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_c0_q   <= out_c0_d;
      out_c1_q   <= out_c1_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign out_c0_tx     = out_c0_q;
  assign out_c1_tx     = out_c1_q;
  assign quiesced      = (state_q == ST_HELD);
  assign drop_cnt      = drop_cnt_q;
  assign err_underflow = err_q;
  assign dbg_state     = state_q;
  assign dbg_rd_cnt    = rd_cnt_q;
  assign dbg_wr_cnt    = wr_cnt_q;

  logic unused_inputs;
  assign unused_inputs = ^{offset[63:42], af_rx};
endmodule

// File: tb/tb_vai_audit_tx.sv
// Directed bench for vai_audit_tx: a queue-based scoreboard checks every audited
// request, and inline checks cover counters, drop count, drain/held states and reset.
module tb_vai_audit_tx;
  import vai_audit_pkg::*;

  localparam int CW = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sub_reset = 1'b0;
  logic [63:0]    offset = '0;
  t_if_ccip_c0_Tx af_c0_tx = '0;
  t_if_ccip_c1_Tx af_c1_tx = '0;
  t_if_ccip_Rx    af_rx = '0;
  t_if_ccip_c0_Tx out_c0_tx;
  t_if_ccip_c1_Tx out_c1_tx;
  logic           quiesced;
  logic [31:0]    drop_cnt;
  logic           err_underflow;
  logic [1:0]     dbg_state;
  logic [CW-1:0]  dbg_rd_cnt, dbg_wr_cnt;

  int checks = 0;
  int errors = 0;
  logic [57:0] exp_c0_q[$];  // {address, mdata}
  logic [61:0] exp_c1_q[$];  // {req_type, address, mdata}

  vai_audit_tx #(.VMID_WIDTH(3), .VMID(5), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .sub_reset(sub_reset), .offset(offset),
    .af_c0_tx(af_c0_tx), .af_c1_tx(af_c1_tx), .af_rx(af_rx),
    .out_c0_tx(out_c0_tx), .out_c1_tx(out_c1_tx), .quiesced(quiesced),
    .drop_cnt(drop_cnt), .err_underflow(err_underflow),
    .dbg_state(dbg_state), .dbg_rd_cnt(dbg_rd_cnt), .dbg_wr_cnt(dbg_wr_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pop expected entries whenever an audited request appears
  always @(negedge clk) begin
    if (!reset && out_c0_tx.valid) begin
      checks++;
      if (exp_c0_q.size() == 0) begin
        errors++;
        $display("FAIL c0_unexpected: got addr %0h mdata %0h expected none", out_c0_tx.hdr.address, out_c0_tx.hdr.mdata);
      end else begin
        logic [57:0] e;
        e = exp_c0_q.pop_front();
        if ({out_c0_tx.hdr.address, out_c0_tx.hdr.mdata} !== e) begin
          errors++;
          $display("FAIL c0_req: got %0h expected %0h", {out_c0_tx.hdr.address, out_c0_tx.hdr.mdata}, e);
        end
      end
    end
    if (!reset && out_c1_tx.valid) begin
      checks++;
      if (exp_c1_q.size() == 0) begin
        errors++;
        $display("FAIL c1_unexpected: got addr %0h mdata %0h expected none", out_c1_tx.hdr.address, out_c1_tx.hdr.mdata);
      end else begin
        logic [61:0] e;
        logic [61:0] g;
        e = exp_c1_q.pop_front();
        g = {out_c1_tx.hdr.req_type, out_c1_tx.hdr.address, out_c1_tx.hdr.mdata};
        if (g !== e) begin
          errors++;
          $display("FAIL c1_req: got %0h expected %0h", g, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_rd(input logic [41:0] addr, input logic [15:0] md, input bit pass,
                         input logic [41:0] exp_addr, input logic [15:0] exp_md);
    af_c0_tx = '0;
    af_c0_tx.hdr.req_type = eREQ_RDLINE_I;
    af_c0_tx.hdr.address  = addr;
    af_c0_tx.hdr.mdata    = md;
    af_c0_tx.valid        = 1'b1;
    if (pass) exp_c0_q.push_back({exp_addr, exp_md});
    tick();
    af_c0_tx = '0;
  endtask

  task automatic send_wr(input t_ccip_c1_req rt, input logic sop, input logic [1:0] len,
                         input logic [41:0] addr, input logic [15:0] md, input bit pass,
                         input logic [41:0] exp_addr, input logic [15:0] exp_md);
    af_c1_tx = '0;
    af_c1_tx.hdr.req_type = rt;
    af_c1_tx.hdr.sop      = sop;
    af_c1_tx.hdr.cl_len   = len;
    af_c1_tx.hdr.address  = addr;
    af_c1_tx.hdr.mdata    = md;
    af_c1_tx.valid        = 1'b1;
    if (pass) exp_c1_q.push_back({rt, exp_addr, exp_md});
    tick();
    af_c1_tx = '0;
  endtask

  task automatic rsp_rd();
    af_rx.c0.hdr.resp_type = eRSP_RDLINE;
    af_rx.c0.rspValid      = 1'b1;
    tick();
    af_rx = '0;
  endtask

  task automatic rsp_wr(input logic fmt, input logic [1:0] num);
    af_rx.c1.hdr.resp_type = eRSP_WRLINE;
    af_rx.c1.hdr.format    = fmt;
    af_rx.c1.hdr.cl_num    = num;
    af_rx.c1.rspValid      = 1'b1;
    tick();
    af_rx = '0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_c0_valid", 64'(out_c0_tx.valid), 64'd0);
    check("rst_c1_valid", 64'(out_c1_tx.valid), 64'd0);
    check("rst_quiesced", 64'(quiesced), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_err", 64'(err_underflow), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // relocation and VMID stamping
    offset = 64'h1000;
    send_rd(42'h20, 16'h0123, 1'b1, 42'h1020, 16'hA123);
    offset = 64'h3FF_FFFF_FFFF;
    send_rd(42'h1, 16'h0000, 1'b0, '0, '0);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    send_rd(42'h0, 16'h0000, 1'b1, 42'h3FF_FFFF_FFFF, 16'hA000);
    send_wr(eREQ_WRFENCE, 1'b0, 2'd0, 42'h5, 16'h1234, 1'b1, 42'h5, 16'hB234);
    check("fence_no_drop", 64'(drop_cnt), 64'd1);
    offset = 64'h1000;
    send_wr(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h40, 16'hFFFF, 1'b1, 42'h1040, 16'hBFFF);
    send_wr(eREQ_WRLINE_I, 1'b0, 2'd0, 42'h80, 16'h0000, 1'b1, 42'h1080, 16'hA000);
    send_wr(eREQ_WRLINE_I, 1'b1, 2'd0, 42'h3FF_FFFF_F000, 16'h0000, 1'b0, '0, '0);
    check("c1_ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    check("rd_cnt_two", 64'(dbg_rd_cnt), 64'd2);
    check("wr_cnt_two", 64'(dbg_wr_cnt), 64'd2);
    do_reset();

    // drain sequence
    offset = 64'h0;
    send_wr(eREQ_WRLINE_I, 1'b1, 2'd3, 42'h100, 16'h0000, 1'b1, 42'h100, 16'hA000);
    send_rd(42'h200, 16'h0001, 1'b1, 42'h200, 16'hA001);
    send_rd(42'h201, 16'h0002, 1'b1, 42'h201, 16'hA002);
    check("wr_cnt_four", 64'(dbg_wr_cnt), 64'd4);
    sub_reset = 1'b1;
    send_rd(42'h202, 16'h0003, 1'b1, 42'h202, 16'hA003);
    check("drain_entered", 64'(dbg_state), 64'd1);
    check("rd_cnt_three", 64'(dbg_rd_cnt), 64'd3);
    af_c0_tx = '0;
    af_c0_tx.hdr.address = 42'h300;
    af_c0_tx.valid = 1'b1;
    af_c1_tx = '0;
    af_c1_tx.hdr.sop = 1'b1;
    af_c1_tx.hdr.address = 42'h340;
    af_c1_tx.valid = 1'b1;
    tick();
    af_c0_tx = '0;
    af_c1_tx = '0;
    check("drain_drop_cnt", 64'(drop_cnt), 64'd2);
    rsp_wr(1'b1, 2'd3);
    check("wr_cnt_zero", 64'(dbg_wr_cnt), 64'd0);
    check("still_drain", 64'(dbg_state), 64'd1);
    rsp_rd();
    rsp_rd();
    check("not_yet_quiesced", 64'(quiesced), 64'd0);
    rsp_rd();
    check("held_state", 64'(dbg_state), 64'd2);
    check("held_quiesced", 64'(quiesced), 64'd1);
    send_rd(42'h500, 16'h0000, 1'b0, '0, '0);
    check("held_drop_cnt", 64'(drop_cnt), 64'd3);
    sub_reset = 1'b0;
    tick();
    check("release_state", 64'(dbg_state), 64'd0);
    check("release_quiesced", 64'(quiesced), 64'd0);
    send_rd(42'h400, 16'h0004, 1'b1, 42'h400, 16'hA004);
    check("release_drop_cnt", 64'(drop_cnt), 64'd3);

    // underflow
    check("err_clear", 64'(err_underflow), 64'd0);
    rsp_wr(1'b0, 2'd0);
    check("uf_wr_cnt", 64'(dbg_wr_cnt), 64'd0);
    check("uf_err_set", 64'(err_underflow), 64'd1);
    tick(); tick(); tick();
    check("uf_err_sticky", 64'(err_underflow), 64'd1);

    // sub_reset falls during drain: exit straight to RUN
    sub_reset = 1'b1;
    tick();
    sub_reset = 1'b0;
    tick();
    check("drain_hold_low", 64'(dbg_state), 64'd1);
    rsp_rd();
    check("drain_to_run", 64'(dbg_state), 64'd0);
    check("drain_to_run_q", 64'(quiesced), 64'd0);

    // async reset mid-drain
    for (int i = 0; i < 7; i++)
      send_rd(42'h600 + 42'(i), 16'(i), 1'b1, 42'h600 + 42'(i), 16'hA000 | 16'(i));
    check("rd_cnt_seven", 64'(dbg_rd_cnt), 64'd7);
    sub_reset = 1'b1;
    tick();
    check("rst_mid_drain_pre", 64'(dbg_state), 64'd1);
    af_c0_tx.valid = 1'b1;
    af_c0_tx.hdr.address = 42'h700;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", 64'(dbg_state), 64'd0);
    check("arst_rd_cnt", 64'(dbg_rd_cnt), 64'd0);
    check("arst_wr_cnt", 64'(dbg_wr_cnt), 64'd0);
    check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("arst_err", 64'(err_underflow), 64'd0);
    check("arst_c0_valid", 64'(out_c0_tx.valid), 64'd0);
    check("arst_c0_addr", 64'(out_c0_tx.hdr.address), 64'd0);
    check("arst_quiesced", 64'(quiesced), 64'd0);
    af_c0_tx = '0;
    sub_reset = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    send_rd(42'h800, 16'h0005, 1'b1, 42'h800, 16'hA005);

    tick(); tick(); tick();
    check("c0_queue_empty", 64'(exp_c0_q.size()), 64'd0);
    check("c1_queue_empty", 64'(exp_c1_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
